axi_multiport_dram_slave: RTL and testbench
===========================================

// Module: axi_multiport_dram_slave
// PURPOSE
//   Parametrised AXI4 slave memory serving RD_PORTS independent read channels and WR_PORTS write channels.
//   Generalises the fixed 2-read/1-write DRAM connection used around the CPU bench.
//   Adds configurable read latency, per-port burst FSMs, a fixed write-collision priority and optional range checking.
//   Sits on the slave side of the flattened *_s_inf buses, in place of the bench-side DRAM model.
// PARAMETERS
//   ID_WIDTH    4     AXI ID width
//   ADDR_WIDTH  32    byte address width
//   DATA_WIDTH  16    beat width; word index = addr >> log2(DATA_WIDTH/8)
//   RD_PORTS    2     number of read channels (>=1)
//   WR_PORTS    1     number of write channels (>=1)
//   MEM_DEPTH   4096  words; power of two
//   RD_LATENCY  2     idle cycles between AR handshake and first rvalid (0..15)
// PORTS
//   clk             in   1                        clock, rising edge
//   rst             in   1                        synchronous reset, active-high
//   arid_s_inf      in   RD_PORTS*ID_WIDTH        read IDs; port p occupies slice p
//   araddr_s_inf    in   RD_PORTS*ADDR_WIDTH      read start byte addresses
//   arlen_s_inf     in   RD_PORTS*7               beats-1
//   arsize_s_inf    in   RD_PORTS*3               ignored
//   arburst_s_inf   in   RD_PORTS*2               ignored; always INCR
//   arvalid_s_inf   in   RD_PORTS                 read address valid
//   arready_s_inf   out  RD_PORTS                 read address ready
//   rid_s_inf       out  RD_PORTS*ID_WIDTH        read ID echo
//   rdata_s_inf     out  RD_PORTS*DATA_WIDTH      read data
//   rresp_s_inf     out  RD_PORTS*2               read response
//   rlast_s_inf     out  RD_PORTS                 last beat
//   rvalid_s_inf    out  RD_PORTS                 read data valid
//   rready_s_inf    in   RD_PORTS                 read data ready
//   awid/awaddr/awlen/awsize/awburst/awvalid_s_inf  in   WR_PORTS*(same widths as AR)  write address
//   awready_s_inf   out  WR_PORTS                 write address ready
//   wdata_s_inf     in   WR_PORTS*DATA_WIDTH      write data
//   wlast_s_inf     in   WR_PORTS                 last write beat
//   wvalid_s_inf    in   WR_PORTS                 write data valid
//   wready_s_inf    out  WR_PORTS                 write data ready
//   bid_s_inf       out  WR_PORTS*ID_WIDTH        write ID echo
//   bresp_s_inf     out  WR_PORTS*2               write response
//   bvalid_s_inf    out  WR_PORTS                 write response valid
//   bready_s_inf    in   WR_PORTS                 write response ready
// BEHAVIOUR
//   Reset: all ready/valid/last outputs 0; all id/data/resp outputs 0; all FSMs idle.
//   Reset mid-burst aborts the burst with no further beats. Memory array is not reset.
//   Read FSM per port: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
//     R_IDLE: arready=1; on arvalid: latch id, word address, beat count = arlen+1.
//     R_WAIT: counts RD_LATENCY cycles; RD_LATENCY=0 goes directly to R_DATA.
//       First rvalid appears RD_LATENCY+1 cycles after the AR handshake.
//     R_DATA: rvalid=1; rdata/rlast/rresp held stable while rvalid&&!rready.
//       Each handshake advances the word address by 1, modulo MEM_DEPTH.
//       rlast=1 on the final beat; handshake on the final beat -> R_IDLE, no bubble.
//       The next AR can be accepted the following cycle.
//   Write FSM per port: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//     W_IDLE: awready=1; latch id, address, beat count.
//     W_DATA: wready=1; each wvalid&&wready writes one word and increments the address.
//       The burst ends on beat count; wlast is sampled only for checking.
//       wlast missing on the final beat, or asserted early -> bresp=2'b10 (SLVERR).
//       All beats are still written.
//     W_RESP: bvalid=1 with bid = latched id; held until bready -> W_IDLE.
//   Collisions: writes landing in the same cycle at the same word -> lowest port index wins.
//     Read and write to the same word in the same cycle -> read returns the old data (read-before-write).
//   rresp/bresp = 2'b00 (OKAY) except as stated.
//   Ports are fully independent; no cross-port ordering is guaranteed.
// CONFIGURATION
//   AXI_DRAM_RANGE_CHECK_EN defined:
//     A burst whose beats cross word MEM_DEPTH-1 is out of range.
//     Out-of-range read beats return data 0 with rresp=2'b10.
//     Out-of-range write beats are dropped; bresp=2'b10.
//   Not defined: addresses wrap modulo MEM_DEPTH; responses are always OKAY
//     (apart from the wlast check).
// STRUCTURE
//   Package axi_dram_pkg: RESP_OKAY/RESP_SLVERR, rd_state_t/wr_state_t enums, AXI_LEN_W=7.
//   Sub-module axi_dram_rd_port: one read FSM plus latency counter, generated RD_PORTS times.
//   Top level contains: memory array, write FSMs, write-priority mux, range check.
// TESTING
//   1. Reset, then idle -> all arready/awready=1, all valid=0, all data/resp/id=0.
//   2. Port0 write: awaddr=0x10, awlen=3, data A0..A3, wlast on beat 4
//      -> bresp=00, bid echoed; words 8..11 hold A0..A3.
//   3. Port0 AR: addr 0x10, len 3; RD_LATENCY=2 -> rvalid 3 cycles after handshake.
//      Data A0..A3, rlast on beat 4. Toggling rready holds data stable.
//   4. Both read ports, same cycle, same address, arid 5 and 9
//      -> identical data, correct rid on each port, independent completion.
//   5. WR_PORTS=2, both write word 20 in the same cycle (0x1111, 0x2222) -> word 20 = 0x1111.
//   6. Burst at word MEM_DEPTH-2, len 3: wraps to words 0,1 without the macro;
//      with the macro, beats 3-4 return rresp=10 and data 0. Reset asserted mid-burst -> rvalid=0 next cycle.

Source files
------------

// File: rtl/axi_dram_pkg.sv
// Shared types and constants for the multiport AXI DRAM slave.
// Used by axi_multiport_dram_slave and axi_dram_rd_port.
package axi_dram_pkg;

   localparam int         AXI_LEN_W   = 7;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/axi_dram_rd_port.sv
// One AXI read channel: AR accept, programmable first-beat latency, INCR burst out.
// Memory is read through mem_addr_o/mem_data_i; mem_oor_i marks a beat as out of range.
module axi_dram_rd_port
   import axi_dram_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int RD_LATENCY = 2,
   parameter int BYTE_SHIFT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   input  logic [AXI_LEN_W-1:0]  arlen_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [ID_WIDTH-1:0]   rid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_oor_i
);

   rd_state_t             state_q;
   logic [3:0]            lat_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [AXI_LEN_W-1:0]  rem_q;
   logic                  arready_q;
   logic                  rvalid_q;
   logic                  rlast_q;
   logic [ID_WIDTH-1:0]   rid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic [ADDR_WIDTH-1:0] ar_word;
   logic [DATA_WIDTH-1:0] beat_data_d;
   logic [1:0]            beat_resp_d;

   assign ar_word = araddr_i >> BYTE_SHIFT;

   // Address of the beat that would be loaded into rdata_q at the next edge.
   always_comb begin
      mem_addr_o = addr_q;
      case (state_q)
         R_IDLE:  mem_addr_o = ar_word;
         R_DATA:  mem_addr_o = addr_q + ADDR_WIDTH'(1);
         default: mem_addr_o = addr_q;
      endcase
   end

   assign beat_data_d = mem_oor_i ? '0 : mem_data_i;
   assign beat_resp_d = mem_oor_i ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= R_IDLE;
         lat_q     <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arready_q && arvalid_i) begin
                  arready_q <= 1'b0;
                  rid_q     <= arid_i;
                  addr_q    <= ar_word;
                  rem_q     <= arlen_i;
                  if (RD_LATENCY == 0) begin
                     state_q  <= R_DATA;
                     rvalid_q <= 1'b1;
                     rlast_q  <= (arlen_i == '0);
                     rdata_q  <= beat_data_d;
                     rresp_q  <= beat_resp_d;
                  end else begin
                     state_q <= R_WAIT;
                     lat_q   <= 4'(RD_LATENCY - 1);
                  end
               end
            end
            R_WAIT: begin
               if (lat_q == '0) begin
                  state_q  <= R_DATA;
                  rvalid_q <= 1'b1;
                  rlast_q  <= (rem_q == '0);
                  rdata_q  <= beat_data_d;
                  rresp_q  <= beat_resp_d;
               end else begin
                  lat_q <= lat_q - 4'd1;
               end
            end
            R_DATA: begin
               if (rready_i) begin
                  if (rem_q == '0) begin
                     state_q   <= R_IDLE;
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + ADDR_WIDTH'(1);
                     rem_q   <= rem_q - AXI_LEN_W'(1);
                     rlast_q <= (rem_q == AXI_LEN_W'(1));
                     rdata_q <= beat_data_d;
                     rresp_q <= beat_resp_d;
                  end
               end
            end
            default: state_q <= R_IDLE;
         endcase
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rlast_o   = rlast_q;
   assign rid_o     = rid_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = rresp_q;

endmodule

// File: rtl/axi_multiport_dram_slave.sv
// AXI4 slave memory with RD_PORTS read and WR_PORTS write channels, lowest write port wins.
// Optional macro AXI_DRAM_RANGE_CHECK_EN: beats past word MEM_DEPTH-1 return/record SLVERR.
module axi_multiport_dram_slave
   import axi_dram_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int RD_PORTS   = 2,
   parameter int WR_PORTS   = 1,
   parameter int MEM_DEPTH  = 4096,
   parameter int RD_LATENCY = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [RD_PORTS*ID_WIDTH-1:0]   arid_s_inf,
   input  logic [RD_PORTS*ADDR_WIDTH-1:0] araddr_s_inf,
   input  logic [RD_PORTS*AXI_LEN_W-1:0]  arlen_s_inf,
   input  logic [RD_PORTS*3-1:0]          arsize_s_inf,
   input  logic [RD_PORTS*2-1:0]          arburst_s_inf,
   input  logic [RD_PORTS-1:0]            arvalid_s_inf,
   output logic [RD_PORTS-1:0]            arready_s_inf,
   output logic [RD_PORTS*ID_WIDTH-1:0]   rid_s_inf,
   output logic [RD_PORTS*DATA_WIDTH-1:0] rdata_s_inf,
   output logic [RD_PORTS*2-1:0]          rresp_s_inf,
   output logic [RD_PORTS-1:0]            rlast_s_inf,
   output logic [RD_PORTS-1:0]            rvalid_s_inf,
   input  logic [RD_PORTS-1:0]            rready_s_inf,
   input  logic [WR_PORTS*ID_WIDTH-1:0]   awid_s_inf,
   input  logic [WR_PORTS*ADDR_WIDTH-1:0] awaddr_s_inf,
   input  logic [WR_PORTS*AXI_LEN_W-1:0]  awlen_s_inf,
   input  logic [WR_PORTS*3-1:0]          awsize_s_inf,
   input  logic [WR_PORTS*2-1:0]          awburst_s_inf,
   input  logic [WR_PORTS-1:0]            awvalid_s_inf,
   output logic [WR_PORTS-1:0]            awready_s_inf,
   input  logic [WR_PORTS*DATA_WIDTH-1:0] wdata_s_inf,
   input  logic [WR_PORTS-1:0]            wlast_s_inf,
   input  logic [WR_PORTS-1:0]            wvalid_s_inf,
   output logic [WR_PORTS-1:0]            wready_s_inf,
   output logic [WR_PORTS*ID_WIDTH-1:0]   bid_s_inf,
   output logic [WR_PORTS*2-1:0]          bresp_s_inf,
   output logic [WR_PORTS-1:0]            bvalid_s_inf,
   input  logic [WR_PORTS-1:0]            bready_s_inf
);

   localparam int IDX_W      = $clog2(MEM_DEPTH);
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [WR_PORTS-1:0]                 wr_en;
   logic [WR_PORTS-1:0][IDX_W-1:0]      wr_idx;
   logic [WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;

   logic unused_cfg;
   assign unused_cfg = ^{arsize_s_inf, arburst_s_inf, awsize_s_inf, awburst_s_inf};

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] fetch_addr;
      logic                  fetch_oor;
`ifdef AXI_DRAM_RANGE_CHECK_EN
      assign fetch_oor = |fetch_addr[ADDR_WIDTH-1:IDX_W];
`else
      logic unused_hi;
      assign unused_hi = ^fetch_addr[ADDR_WIDTH-1:IDX_W];
      assign fetch_oor = 1'b0;
`endif
      axi_dram_rd_port #(
         .ID_WIDTH   (ID_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .RD_LATENCY (RD_LATENCY),
         .BYTE_SHIFT (BYTE_SHIFT)
      ) u_rd (
         .clk_i      (clk),
         .rst_i      (rst),
         .arid_i     (arid_s_inf[p*ID_WIDTH +: ID_WIDTH]),
         .araddr_i   (araddr_s_inf[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .arlen_i    (arlen_s_inf[p*AXI_LEN_W +: AXI_LEN_W]),
         .arvalid_i  (arvalid_s_inf[p]),
         .arready_o  (arready_s_inf[p]),
         .rid_o      (rid_s_inf[p*ID_WIDTH +: ID_WIDTH]),
         .rdata_o    (rdata_s_inf[p*DATA_WIDTH +: DATA_WIDTH]),
         .rresp_o    (rresp_s_inf[p*2 +: 2]),
         .rlast_o    (rlast_s_inf[p]),
         .rvalid_o   (rvalid_s_inf[p]),
         .rready_i   (rready_s_inf[p]),
         .mem_addr_o (fetch_addr),
         .mem_data_i (mem[fetch_addr[IDX_W-1:0]]),
         .mem_oor_i  (fetch_oor)
      );
   end

   for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr
      wr_state_t             state_q;
      logic                  awready_q;
      logic                  wready_q;
      logic                  bvalid_q;
      logic [ID_WIDTH-1:0]   bid_q;
      logic [1:0]            bresp_q;
      logic [ADDR_WIDTH-1:0] addr_q;
      logic [AXI_LEN_W-1:0]  rem_q;
      logic                  err_q;
      logic                  beat;
      logic                  beat_oor;
      logic                  wlast_bad;

      assign beat = (state_q == W_DATA) && wready_q && wvalid_s_inf[p];
`ifdef AXI_DRAM_RANGE_CHECK_EN
      assign beat_oor = |addr_q[ADDR_WIDTH-1:IDX_W];
`else
      logic unused_hi;
      assign unused_hi = ^addr_q[ADDR_WIDTH-1:IDX_W];
      assign beat_oor  = 1'b0;
`endif
      // Beat count ends the burst; wlast only has to agree with it.
      assign wlast_bad = (rem_q == '0) ? !wlast_s_inf[p] : wlast_s_inf[p];

      assign wr_en[p]   = beat && !beat_oor;
      assign wr_idx[p]  = addr_q[IDX_W-1:0];
      assign wr_data[p] = wdata_s_inf[p*DATA_WIDTH +: DATA_WIDTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
         end else begin
            case (state_q)
               W_IDLE: begin
                  awready_q <= 1'b1;
                  if (awready_q && awvalid_s_inf[p]) begin
                     awready_q <= 1'b0;
                     wready_q  <= 1'b1;
                     bid_q     <= awid_s_inf[p*ID_WIDTH +: ID_WIDTH];
                     addr_q    <= awaddr_s_inf[p*ADDR_WIDTH +: ADDR_WIDTH] >> BYTE_SHIFT;
                     rem_q     <= awlen_s_inf[p*AXI_LEN_W +: AXI_LEN_W];
                     err_q     <= 1'b0;
                     state_q   <= W_DATA;
                  end
               end
               W_DATA: begin
                  if (beat) begin
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                     rem_q  <= rem_q - AXI_LEN_W'(1);
                     if (rem_q == '0) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (err_q || wlast_bad || beat_oor) ? RESP_SLVERR : RESP_OKAY;
                        state_q  <= W_RESP;
                     end else begin
                        err_q <= err_q || wlast_bad || beat_oor;
                     end
                  end
               end
               W_RESP: begin
                  if (bready_s_inf[p]) begin
                     bvalid_q  <= 1'b0;
                     awready_q <= 1'b1;
                     state_q   <= W_IDLE;
                  end
               end
               default: state_q <= W_IDLE;
            endcase
         end
      end

      assign awready_s_inf[p]              = awready_q;
      assign wready_s_inf[p]               = wready_q;
      assign bvalid_s_inf[p]               = bvalid_q;
      assign bid_s_inf[p*ID_WIDTH +: ID_WIDTH] = bid_q;
      assign bresp_s_inf[p*2 +: 2]         = bresp_q;
   end

   // Descending loop so the lowest-index port's write is the one that lands.
   always_ff @(posedge clk) begin
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
         if (wr_en[p]) mem[wr_idx[p]] <= wr_data[p];
      end
   end

endmodule

// File: tb/tb_axi_multiport_dram_slave.sv
// Directed bench for axi_multiport_dram_slave with two read and two write ports.
// Expected values for range-checked builds follow AXI_DRAM_RANGE_CHECK_EN.
module tb_axi_multiport_dram_slave;

   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 16;
   localparam int RP  = 2;
   localparam int WP  = 2;
   localparam int LW  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [RP*IDW-1:0] arid_s_inf    = '0;
   logic [RP*AW-1:0]  araddr_s_inf  = '0;
   logic [RP*LW-1:0]  arlen_s_inf   = '0;
   logic [RP*3-1:0]   arsize_s_inf  = '0;
   logic [RP*2-1:0]   arburst_s_inf = '0;
   logic [RP-1:0]     arvalid_s_inf = '0;
   logic [RP-1:0]     arready_s_inf;
   logic [RP*IDW-1:0] rid_s_inf;
   logic [RP*DW-1:0]  rdata_s_inf;
   logic [RP*2-1:0]   rresp_s_inf;
   logic [RP-1:0]     rlast_s_inf;
   logic [RP-1:0]     rvalid_s_inf;
   logic [RP-1:0]     rready_s_inf  = '0;
   logic [WP*IDW-1:0] awid_s_inf    = '0;
   logic [WP*AW-1:0]  awaddr_s_inf  = '0;
   logic [WP*LW-1:0]  awlen_s_inf   = '0;
   logic [WP*3-1:0]   awsize_s_inf  = '0;
   logic [WP*2-1:0]   awburst_s_inf = '0;
   logic [WP-1:0]     awvalid_s_inf = '0;
   logic [WP-1:0]     awready_s_inf;
   logic [WP*DW-1:0]  wdata_s_inf   = '0;
   logic [WP-1:0]     wlast_s_inf   = '0;
   logic [WP-1:0]     wvalid_s_inf  = '0;
   logic [WP-1:0]     wready_s_inf;
   logic [WP*IDW-1:0] bid_s_inf;
   logic [WP*2-1:0]   bresp_s_inf;
   logic [WP-1:0]     bvalid_s_inf;
   logic [WP-1:0]     bready_s_inf  = '0;

   int n_tests = 0;
   int n_fail  = 0;

   axi_multiport_dram_slave #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RD_PORTS(RP), .WR_PORTS(WP), .MEM_DEPTH(4096), .RD_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .arid_s_inf(arid_s_inf), .araddr_s_inf(araddr_s_inf), .arlen_s_inf(arlen_s_inf),
      .arsize_s_inf(arsize_s_inf), .arburst_s_inf(arburst_s_inf),
      .arvalid_s_inf(arvalid_s_inf), .arready_s_inf(arready_s_inf),
      .rid_s_inf(rid_s_inf), .rdata_s_inf(rdata_s_inf), .rresp_s_inf(rresp_s_inf),
      .rlast_s_inf(rlast_s_inf), .rvalid_s_inf(rvalid_s_inf), .rready_s_inf(rready_s_inf),
      .awid_s_inf(awid_s_inf), .awaddr_s_inf(awaddr_s_inf), .awlen_s_inf(awlen_s_inf),
      .awsize_s_inf(awsize_s_inf), .awburst_s_inf(awburst_s_inf),
      .awvalid_s_inf(awvalid_s_inf), .awready_s_inf(awready_s_inf),
      .wdata_s_inf(wdata_s_inf), .wlast_s_inf(wlast_s_inf), .wvalid_s_inf(wvalid_s_inf),
      .wready_s_inf(wready_s_inf),
      .bid_s_inf(bid_s_inf), .bresp_s_inf(bresp_s_inf), .bvalid_s_inf(bvalid_s_inf),
      .bready_s_inf(bready_s_inf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ar_issue(input int p, input logic [3:0] id, input logic [31:0] a,
                           input logic [6:0] len);
      arid_s_inf[p*IDW +: IDW] = id;
      araddr_s_inf[p*AW +: AW] = a;
      arlen_s_inf[p*LW +: LW]  = len;
      arvalid_s_inf[p]         = 1'b1;
      tick();
      arvalid_s_inf[p]         = 1'b0;
   endtask

   // bad: 0 = wlast on final beat, 1 = wlast never, 2 = wlast on every beat
   task automatic wr_burst(input int p, input logic [3:0] id, input logic [31:0] a,
                           input logic [6:0] len, input logic [15:0] d0, input int bad);
      awid_s_inf[p*IDW +: IDW] = id;
      awaddr_s_inf[p*AW +: AW] = a;
      awlen_s_inf[p*LW +: LW]  = len;
      awvalid_s_inf[p]         = 1'b1;
      tick();
      awvalid_s_inf[p]         = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata_s_inf[p*DW +: DW] = 16'(int'(d0) + b);
         wvalid_s_inf[p]         = 1'b1;
         wlast_s_inf[p]          = (bad == 0) ? (b == int'(len)) : (bad == 2);
         tick();
      end
      wvalid_s_inf[p] = 1'b0;
      wlast_s_inf[p]  = 1'b0;
   endtask

   task automatic b_take(input int p);
      bready_s_inf[p] = 1'b1;
      tick();
      bready_s_inf[p] = 1'b0;
      check("bvalid_drop", 32'(bvalid_s_inf[p]), 32'd0);
   endtask

   logic [15:0] exp_d [4];
   logic [1:0]  exp_r [4];
   logic [1:0]  exp_b;

   initial begin
      // reset state
      repeat (3) tick();
      check("rst_arready", 32'(arready_s_inf), 32'd0);
      check("rst_awready", 32'(awready_s_inf), 32'd0);
      check("rst_wready",  32'(wready_s_inf),  32'd0);
      check("rst_rvalid",  32'(rvalid_s_inf),  32'd0);
      check("rst_rlast",   32'(rlast_s_inf),   32'd0);
      check("rst_bvalid",  32'(bvalid_s_inf),  32'd0);
      check("rst_rdata",   rdata_s_inf,        32'd0);
      check("rst_rid",     32'(rid_s_inf),     32'd0);
      check("rst_rresp",   32'(rresp_s_inf),   32'd0);
      check("rst_bid",     32'(bid_s_inf),     32'd0);
      check("rst_bresp",   32'(bresp_s_inf),   32'd0);
      rst = 1'b0;
      tick();
      tick();
      check("idle_arready", 32'(arready_s_inf), 32'h3);
      check("idle_awready", 32'(awready_s_inf), 32'h3);
      check("idle_rvalid",  32'(rvalid_s_inf),  32'h0);

      // write burst A0..A3 to words 8..11
      wr_burst(0, 4'h3, 32'h10, 7'd3, 16'h00A0, 0);
      check("wr_bvalid",  32'(bvalid_s_inf[0]),  32'd1);
      check("wr_bresp",   32'(bresp_s_inf[1:0]), 32'd0);
      check("wr_bid",     32'(bid_s_inf[3:0]),   32'h3);
      check("wr_awready", 32'(awready_s_inf[0]), 32'd0);
      b_take(0);
      check("wr_awready_back", 32'(awready_s_inf[0]), 32'd1);

      // read burst with latency and rready backpressure
      ar_issue(0, 4'h6, 32'h10, 7'd3);
      check("rd_lat_c1", 32'(rvalid_s_inf[0]), 32'd0);
      tick();
      check("rd_lat_c2", 32'(rvalid_s_inf[0]), 32'd0);
      tick();
      check("rd_lat_c3", 32'(rvalid_s_inf[0]), 32'd1);
      check("rd_rid",    32'(rid_s_inf[3:0]),  32'h6);
      for (int b = 0; b < 4; b++) begin
         check("rd_data",  32'(rdata_s_inf[15:0]), 32'(16'h00A0 + b));
         check("rd_last",  32'(rlast_s_inf[0]),    32'(b == 3));
         check("rd_resp",  32'(rresp_s_inf[1:0]),  32'd0);
         tick();
         check("rd_hold_v", 32'(rvalid_s_inf[0]),  32'd1);
         check("rd_hold_d", 32'(rdata_s_inf[15:0]), 32'(16'h00A0 + b));
         rready_s_inf[0] = 1'b1;
         tick();
         rready_s_inf[0] = 1'b0;
      end
      check("rd_done_v",   32'(rvalid_s_inf[0]),  32'd0);
      check("rd_arready",  32'(arready_s_inf[0]), 32'd1);

      // both read ports, same cycle, same address
      arid_s_inf   = {4'h9, 4'h5};
      araddr_s_inf = {32'h10, 32'h10};
      arlen_s_inf  = {7'd1, 7'd1};
      arvalid_s_inf = 2'b11;
      tick();
      arvalid_s_inf = 2'b00;
      tick();
      tick();
      check("dual_rvalid", 32'(rvalid_s_inf), 32'h3);
      check("dual_rdata",  rdata_s_inf,       32'h00A0_00A0);
      check("dual_rid",    32'(rid_s_inf),    32'h95);
      rready_s_inf = 2'b01;
      tick();
      check("dual_p0_b1",   32'(rdata_s_inf[15:0]),  32'h00A1);
      check("dual_p0_last", 32'(rlast_s_inf),        32'h1);
      check("dual_p1_hold", 32'(rdata_s_inf[31:16]), 32'h00A0);
      rready_s_inf = 2'b11;
      tick();
      check("dual_rvalid2", 32'(rvalid_s_inf),       32'h2);
      check("dual_p1_b1",   32'(rdata_s_inf[31:16]), 32'h00A1);
      check("dual_p1_last", 32'(rlast_s_inf[1]),     32'h1);
      tick();
      rready_s_inf = 2'b00;
      check("dual_done", 32'(rvalid_s_inf), 32'h0);

      // simultaneous writes to word 20: port 0 wins
      awid_s_inf    = {4'h2, 4'h1};
      awaddr_s_inf  = {32'h28, 32'h28};
      awlen_s_inf   = {7'd0, 7'd0};
      awvalid_s_inf = 2'b11;
      tick();
      awvalid_s_inf = 2'b00;
      wdata_s_inf   = {16'h2222, 16'h1111};
      wvalid_s_inf  = 2'b11;
      wlast_s_inf   = 2'b11;
      tick();
      wvalid_s_inf  = 2'b00;
      wlast_s_inf   = 2'b00;
      check("coll_bvalid", 32'(bvalid_s_inf), 32'h3);
      check("coll_bresp",  32'(bresp_s_inf),  32'h0);
      check("coll_bid",    32'(bid_s_inf),    32'h21);
      bready_s_inf = 2'b11;
      tick();
      bready_s_inf = 2'b00;
      ar_issue(1, 4'h7, 32'h28, 7'd0);
      tick();
      tick();
      check("coll_rvalid", 32'(rvalid_s_inf[1]),     32'd1);
      check("coll_data",   32'(rdata_s_inf[31:16]),  32'h1111);
      check("coll_rlast",  32'(rlast_s_inf[1]),      32'd1);
      rready_s_inf[1] = 1'b1;
      tick();
      rready_s_inf[1] = 1'b0;

      // wlast protocol errors
      wr_burst(1, 4'hC, 32'h3C, 7'd1, 16'h0030, 2);
      check("early_wlast_bresp", 32'(bresp_s_inf[3:2]), 32'h2);
      check("early_wlast_bid",   32'(bid_s_inf[7:4]),   32'hC);
      b_take(1);
      wr_burst(0, 4'hD, 32'h40, 7'd0, 16'h0040, 1);
      check("miss_wlast_bresp", 32'(bresp_s_inf[1:0]), 32'h2);
      b_take(0);
      ar_issue(1, 4'h1, 32'h3C, 7'd1);
      tick();
      tick();
      check("early_wlast_data0", 32'(rdata_s_inf[31:16]), 32'h0030);
      rready_s_inf[1] = 1'b1;
      tick();
      check("early_wlast_data1", 32'(rdata_s_inf[31:16]), 32'h0031);
      tick();
      rready_s_inf[1] = 1'b0;

      // burst across the top of memory
`ifdef AXI_DRAM_RANGE_CHECK_EN
      exp_d = '{16'h00B0, 16'h00B1, 16'h0000, 16'h0000};
      exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
      exp_b = 2'b10;
`else
      exp_d = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
      exp_r = '{2'b00, 2'b00, 2'b00, 2'b00};
      exp_b = 2'b00;
`endif
      wr_burst(0, 4'h4, 32'h1FFC, 7'd3, 16'h00B0, 0);
      check("top_bresp", 32'(bresp_s_inf[1:0]), 32'(exp_b));
      b_take(0);
      ar_issue(0, 4'h2, 32'h1FFC, 7'd3);
      tick();
      tick();
      rready_s_inf[0] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         check("top_rvalid", 32'(rvalid_s_inf[0]),   32'd1);
         check("top_rdata",  32'(rdata_s_inf[15:0]), 32'(exp_d[b]));
         check("top_rresp",  32'(rresp_s_inf[1:0]),  32'(exp_r[b]));
         check("top_rlast",  32'(rlast_s_inf[0]),    32'(b == 3));
         tick();
      end
      rready_s_inf[0] = 1'b0;
      check("top_done", 32'(rvalid_s_inf[0]), 32'd0);

      // reset in the middle of a read burst
      ar_issue(1, 4'h1, 32'h10, 7'd3);
      tick();
      tick();
      check("mid_rvalid_pre", 32'(rvalid_s_inf[1]), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_rvalid_rst", 32'(rvalid_s_inf[1]),     32'd0);
      check("mid_rdata_rst",  32'(rdata_s_inf[31:16]),  32'd0);
      rst = 1'b0;
      tick();
      tick();
      check("mid_rvalid_after", 32'(rvalid_s_inf), 32'd0);
      ar_issue(0, 4'h8, 32'h10, 7'd0);
      tick();
      tick();
      check("mem_kept_v", 32'(rvalid_s_inf[0]),   32'd1);
      check("mem_kept_d", 32'(rdata_s_inf[15:0]), 32'h00A0);
      check("mem_kept_id", 32'(rid_s_inf[3:0]),   32'h8);
      rready_s_inf[0] = 1'b1;
      tick();
      rready_s_inf[0] = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
